// File: rtl/data_memory_sized_if.sv
// data_memory_sized_if: request/response bus (master = requester, slave = memory)
interface data_memory_sized_if;
  logic req_valid, req_ready, req_we, req_unsigned;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata;
  logic resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_memory_sized.sv
// data_memory_sized: byte/half/word data memory with fixed read latency; ports clk, rst_n (async low), bus (slave request/response)
module data_memory_sized #(
  parameter int DEPTH_WORDS = 64,
  parameter int READ_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  data_memory_sized_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic [1:0] r_cnt, r_size;
  logic r_we, r_uns, r_resp_valid, r_resp_err;
  logic [31:0] r_addr, r_wdata, r_resp_rdata;
  logic [31:0] r_mem [DEPTH_WORDS] = '{default: '0};
  logic w_acc, w_fire, w_err;
  logic [AW-1:0] w_idx;
  logic [3:0] w_be;
  logic [31:0] w_wd, w_word, w_rdata;
  logic [7:0] w_byte;
  logic [15:0] w_half;
  assign w_acc = bus.req_valid && r_state == IDLE;
  assign w_fire = r_state == RESP && !r_resp_valid;
  assign w_idx = r_addr[AW+1:2];
  assign w_err = r_size == 2'b11 || (r_size == 2'b01 && r_addr[0]) ||
                 (r_size == 2'b10 && r_addr[1:0] != 2'b00) ||
                 {2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign w_be = r_size == 2'b00 ? 4'b0001 << r_addr[1:0] :
                r_size == 2'b01 ? (r_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wd = r_size == 2'b00 ? {4{r_wdata[7:0]}} :
                r_size == 2'b01 ? {2{r_wdata[15:0]}} : r_wdata;
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];
  assign w_rdata = r_we || w_err ? '0 :
                   r_size == 2'b00 ? {{24{w_byte[7] & ~r_uns}}, w_byte} :
                   r_size == 2'b01 ? {{16{w_half[15] & ~r_uns}}, w_half} : w_word;
  assign bus.req_ready = r_state == IDLE;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err = r_resp_err;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_acc ? (READ_LAT == 1 ? RESP : WAIT) : IDLE;
      WAIT: w_next = r_cnt == 2'd0 ? RESP : WAIT;
      RESP: w_next = r_resp_valid && bus.resp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_we <= 1'b0;
      r_size <= '0;
      r_uns <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_we <= bus.req_we;
        r_size <= bus.req_size;
        r_uns <= bus.req_unsigned;
        r_addr <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_cnt <= 2'(READ_LAT > 1 ? READ_LAT - 2 : 0);
      end else if (r_state == WAIT && r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
      if (w_fire) begin
        r_resp_valid <= 1'b1;
        r_resp_rdata <= w_rdata;
        r_resp_err <= w_err;
      end else if (r_resp_valid && bus.resp_ready) r_resp_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (w_fire && r_we && !w_err)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
endmodule

// File: tb/tb_data_memory_sized.sv
// tb_data_memory_sized: directed and model-checked stimulus for data_memory_sized at READ_LAT 1 and 3
module tb_data_memory_sized;
  logic clk = 1'b0, rst_n = 1'b0, rst3_n = 1'b0;
  logic sel = 1'b0, v = 1'b0, rr = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0] sz = '0;
  logic [31:0] addr = '0, wd = '0;
  logic rdy, rv, rerr;
  logic [31:0] rdat;
  logic [7:0] mdl [256];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  data_memory_sized_if b1 ();
  data_memory_sized_if b3 ();
  assign b1.req_valid = v & ~sel;
  assign b3.req_valid = v & sel;
  assign b1.resp_ready = rr & ~sel;
  assign b3.resp_ready = rr & sel;
  assign b1.req_we = we;
  assign b3.req_we = we;
  assign b1.req_size = sz;
  assign b3.req_size = sz;
  assign b1.req_unsigned = uns;
  assign b3.req_unsigned = uns;
  assign b1.req_addr = addr;
  assign b3.req_addr = addr;
  assign b1.req_wdata = wd;
  assign b3.req_wdata = wd;
  assign rdy = sel ? b3.req_ready : b1.req_ready;
  assign rv = sel ? b3.resp_valid : b1.resp_valid;
  assign rdat = sel ? b3.resp_rdata : b1.resp_rdata;
  assign rerr = sel ? b3.resp_err : b1.resp_err;
  data_memory_sized #(.DEPTH_WORDS(64), .READ_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  data_memory_sized #(.DEPTH_WORDS(64), .READ_LAT(3)) u3 (.clk(clk), .rst_n(rst3_n), .bus(b3));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    we = w; sz = s; uns = u; addr = a; wd = d; v = 1'b1;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept delay", n, 0);
    @(posedge clk);
    #1 v = 1'b0;
    we = ~w; sz = ~s; uns = ~u; addr = ~a; wd = ~d;
  endtask
  task automatic wait_resp(input int lat_exp);
    int lat = 0;
    while (!rv && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", lat, lat_exp);
  endtask
  task automatic xact(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a, input logic [31:0] d,
                      input int lat, input int stall, input logic [31:0] exp_d, input logic exp_e, input string tag);
    issue(w, s, u, a, d);
    wait_resp(lat);
    chk({tag, " rdata"}, rdat, exp_d);
    chk({tag, " err"}, rerr, exp_e);
    for (int i = 0; i < stall; i++) begin
      v = 1'b1; we = 1'b1; sz = 2'b10; addr = 32'h0C; wd = 32'hBADBAD00;
      @(posedge clk);
      #1;
      chk({tag, " stall valid"}, rv, 1);
      chk({tag, " stall rdata"}, rdat, exp_d);
      chk({tag, " stall err"}, rerr, exp_e);
      chk({tag, " stall ready"}, rdy, 0);
    end
    v = 1'b0;
    rr = 1'b1;
    @(posedge clk);
    #1 rr = 1'b0;
    chk({tag, " valid cleared"}, rv, 0);
    chk({tag, " rdata held"}, rdat, exp_d);
    chk({tag, " ready after"}, rdy, 1);
  endtask
  task automatic mrun(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic e;
    int nb;
    r = '0;
    e = s == 2'd3 || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0) || a >= 32'd256;
    nb = s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
    if (!e)
      for (int i = 0; i < nb; i++)
        if (w) mdl[int'(a[7:0]) + i] = d[8*i +: 8];
        else r[8*i +: 8] = mdl[int'(a[7:0]) + i];
    if (!e && !w && !u && s != 2'd2 && r[8*nb-1])
      for (int j = 8 * nb; j < 32; j++) r[j] = 1'b1;
    xact(w, s, u, a, d, 3, int'($urandom_range(0, 3)), r, e, "rand");
  endtask
  initial begin
    #12;
    chk("reset valid", rv, 0);
    chk("reset rdata", rdat, 0);
    chk("reset err", rerr, 0);
    chk("reset ready", rdy, 1);
    @(negedge clk);
    rst_n = 1'b1;
    rst3_n = 1'b1;
    @(posedge clk);
    #1 chk("ready after reset", rdy, 1);
    xact(1, 2, 0, 'h10, 'hDEADBEEF, 1, 0, 0, 0, "st word");
    xact(0, 2, 0, 'h10, 0, 1, 2, 'hDEADBEEF, 0, "ld word");
    xact(1, 0, 0, 'h11, 'hFFFFFF7F, 1, 0, 0, 0, "st byte");
    xact(0, 2, 0, 'h10, 0, 1, 0, 'hDEAD7FEF, 0, "ld word2");
    xact(0, 0, 0, 'h13, 0, 1, 0, 'hFFFFFFDE, 0, "ld byte s");
    xact(0, 0, 1, 'h13, 0, 1, 0, 'h000000DE, 0, "ld byte u");
    xact(0, 1, 0, 'h12, 0, 1, 0, 'hFFFFDEAD, 0, "ld half s");
    xact(0, 1, 1, 'h12, 0, 1, 0, 'h0000DEAD, 0, "ld half u");
    xact(0, 1, 0, 'h10, 0, 1, 0, 'h00007FEF, 0, "ld half lo");
    xact(1, 1, 0, 'h16, 'h1234BEEF, 1, 0, 0, 0, "st half");
    xact(0, 2, 0, 'h14, 0, 1, 0, 'hBEEF0000, 0, "ld word3");
    xact(0, 1, 0, 'h01, 0, 1, 0, 0, 1, "err half odd");
    xact(0, 2, 0, 'h02, 0, 1, 0, 0, 1, "err word mis");
    xact(0, 3, 0, 'h10, 0, 1, 0, 0, 1, "err size");
    xact(0, 2, 0, 'h100, 0, 1, 0, 0, 1, "err range ld");
    xact(1, 2, 0, 'h100, 'h1, 1, 0, 0, 1, "err range st");
    xact(1, 2, 0, 'h12, 'h11111111, 1, 0, 0, 1, "err st mis");
    xact(1, 1, 0, 'h13, 'h2222, 1, 0, 0, 1, "err st half");
    xact(1, 3, 0, 'h14, 'h33333333, 1, 0, 0, 1, "err st size");
    xact(0, 2, 0, 'h10, 0, 1, 0, 'hDEAD7FEF, 0, "kept 0x10");
    xact(0, 2, 0, 'h14, 0, 1, 0, 'hBEEF0000, 0, "kept 0x14");
    xact(1, 0, 0, 'hFF, 'hA5, 1, 0, 0, 0, "st top byte");
    xact(0, 0, 0, 'hFF, 0, 1, 0, 'hFFFFFFA5, 0, "ld top byte");
    xact(0, 2, 0, 'hFC, 0, 1, 0, 'hA5000000, 0, "ld top word");
    sel = 1'b1;
    xact(1, 2, 0, 'h08, 'hCAFEF00D, 3, 5, 0, 0, "l3 st");
    xact(0, 2, 0, 'h08, 0, 3, 0, 'hCAFEF00D, 0, "l3 ld");
    issue(0, 2, 0, 'h08, 0);
    wait_resp(3);
    chk("l3 pre-reset rdata", rdat, 'hCAFEF00D);
    @(negedge clk);
    rst3_n = 1'b0;
    #1;
    chk("async rst valid", rv, 0);
    chk("async rst rdata", rdat, 0);
    chk("async rst ready", rdy, 1);
    @(negedge clk);
    rst3_n = 1'b1;
    issue(1, 2, 0, 'h20, 'h12345678);
    @(negedge clk);
    rst3_n = 1'b0;
    #1;
    chk("wait rst valid", rv, 0);
    chk("wait rst rdata", rdat, 0);
    chk("wait rst err", rerr, 0);
    chk("wait rst ready", rdy, 1);
    @(negedge clk);
    rst3_n = 1'b1;
    xact(0, 2, 0, 'h20, 0, 3, 0, 0, 0, "dropped st");
    xact(0, 2, 0, 'h0C, 0, 3, 0, 0, 0, "stall spam");
    xact(0, 2, 0, 'h08, 0, 3, 0, 'hCAFEF00D, 0, "kept after rst");
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    mdl[8] = 8'h0D; mdl[9] = 8'hF0; mdl[10] = 8'hFE; mdl[11] = 8'hCA;
    for (int k = 0; k < 40; k++)
      mrun(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           32'($urandom_range(0, 271)), $urandom);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
